// File: rtl/axis_vector_driver.sv
// axis_vector_driver: streams operand frames from a table to an accelerator, collects each result
// frame and scores the last result word against an expected table for on-chip self-test.
module axis_vector_driver #(
   parameter int DATA_WIDTH     = 32,
   parameter int FRAME_LEN      = 2,
   parameter int NUM_VECTORS    = 8,
   parameter int ADDR_W         = 5,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    s00_axi_aclk,
   input  logic                    s00_axi_areset,
   input  logic                    run,
   input  logic                    cfg_wr_en,
   input  logic                    cfg_wr_kind,
   input  logic [ADDR_W-1:0]       cfg_wr_addr,
   input  logic [DATA_WIDTH-1:0]   cfg_wr_data,
   output logic                    m00_axis_tvalid,
   output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                    m00_axis_tlast,
   input  logic                    m00_axis_tready,
   output logic                    acc_start,
   input  logic                    s00_axis_tvalid,
   input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic                    s00_axis_tlast,
   output logic                    s00_axis_tready,
   output logic                    busy,
   output logic                    done,
   output logic [7:0]              pass_count,
   output logic [7:0]              fail_count,
   output logic [7:0]              first_fail_idx,
   output logic [DATA_WIDTH-1:0]   first_fail_data,
   output logic                    timeout
);
   localparam int DEPTH = NUM_VECTORS * FRAME_LEN;
   localparam int VW = NUM_VECTORS > 1 ? $clog2(NUM_VECTORS) : 1;
   localparam int BW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
   localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [ADDR_W-1:0] FL_A = ADDR_W'(FRAME_LEN);

   typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_START, S_RECV, S_CHECK, S_DONE} state_t;

   logic [DATA_WIDTH-1:0] r_op  [2**ADDR_W];
   logic [DATA_WIDTH-1:0] r_exp [2**VW];
   state_t                r_state;
   logic [VW-1:0]         r_vec;
   logic [BW-1:0]         r_beat;
   logic [TW-1:0]         r_cnt;
   logic [DATA_WIDTH-1:0] r_res, r_tdata, r_ff_data;
   logic [7:0]            r_pass, r_fail, r_ff_idx;
   logic                  r_vec_tmo, r_tvalid, r_tlast, r_acc_start, r_s_tready;
   logic                  r_busy, r_done, r_timeout;
   logic [ADDR_W-1:0]     w_base, w_cur;
   logic [BW-1:0]         w_beat_nxt;
   logic                  w_op_ok, w_exp_ok, w_rx, w_match, w_last_vec;

   always_comb begin
      w_base     = ADDR_W'(r_vec) * FL_A;
      w_cur      = w_base + ADDR_W'(r_beat);
      w_beat_nxt = r_beat + BW'(1);
      w_op_ok    = {1'b0, cfg_wr_addr} < (ADDR_W+1)'(DEPTH);
      w_exp_ok   = {1'b0, cfg_wr_addr} < (ADDR_W+1)'(NUM_VECTORS);
      w_rx       = r_s_tready & s00_axis_tvalid;
      w_match    = !r_vec_tmo && r_res == r_exp[r_vec];
      w_last_vec = r_vec == VW'(NUM_VECTORS-1);
   end

   // Tables keep their contents across reset and are frozen while a pass runs.
   always_ff @(posedge s00_axi_aclk) begin
      if (cfg_wr_en && !r_busy && !cfg_wr_kind && w_op_ok) r_op[cfg_wr_addr] <= cfg_wr_data;
      if (cfg_wr_en && !r_busy && cfg_wr_kind && w_exp_ok) r_exp[cfg_wr_addr[VW-1:0]] <= cfg_wr_data;
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         r_state     <= S_IDLE;
         r_vec       <= '0;
         r_beat      <= '0;
         r_cnt       <= '0;
         r_res       <= '0;
         r_vec_tmo   <= 1'b0;
         r_tvalid    <= 1'b0;
         r_tdata     <= '0;
         r_tlast     <= 1'b0;
         r_acc_start <= 1'b0;
         r_s_tready  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= '0;
         r_fail      <= '0;
         r_ff_idx    <= '0;
         r_ff_data   <= '0;
         r_timeout   <= 1'b0;
      end else begin
         r_acc_start <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: if (run) begin
               r_pass    <= '0;
               r_fail    <= '0;
               r_ff_idx  <= '0;
               r_ff_data <= '0;
               r_timeout <= 1'b0;
               r_vec     <= '0;
               r_beat    <= '0;
               r_busy    <= 1'b1;
               r_done    <= 1'b0;
               r_tvalid  <= 1'b1;
               r_tdata   <= r_op[ADDR_W'(0)];
               r_tlast   <= FRAME_LEN == 1;
               r_state   <= S_SEND;
            end
            // Next beat is preloaded on each handshake so beats flow back to back.
            S_SEND: if (m00_axis_tready) begin
               r_beat <= w_beat_nxt;
               if (r_tlast) begin
                  r_tvalid <= 1'b0;
                  r_state  <= S_GAP;
               end else begin
                  r_tdata <= r_op[w_cur + ADDR_W'(1)];
                  r_tlast <= w_beat_nxt == BW'(FRAME_LEN-1);
               end
            end
            S_GAP: begin
               r_acc_start <= 1'b1;
               r_state     <= S_START;
            end
            S_START: begin
               r_s_tready <= 1'b1;
               r_cnt      <= '0;
               r_vec_tmo  <= 1'b0;
               r_state    <= S_RECV;
            end
            S_RECV: begin
               if (w_rx) r_res <= s00_axis_tdata;
               if (w_rx && s00_axis_tlast) begin
                  r_s_tready <= 1'b0;
                  r_state    <= S_CHECK;
               end else if (r_cnt == TW'(TIMEOUT_CYCLES-1)) begin
                  r_s_tready <= 1'b0;
                  r_res      <= '0;
                  r_vec_tmo  <= 1'b1;
                  r_timeout  <= 1'b1;
                  r_state    <= S_CHECK;
               end else r_cnt <= r_cnt + TW'(1);
            end
            S_CHECK: begin
               if (w_match) begin
                  if (r_pass != 8'hFF) r_pass <= r_pass + 8'd1;
               end else begin
                  if (r_fail != 8'hFF) r_fail <= r_fail + 8'd1;
                  if (r_fail == 8'd0) begin
                     r_ff_idx  <= 8'(r_vec);
                     r_ff_data <= r_res;
                  end
               end
               if (w_last_vec) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_vec    <= r_vec + VW'(1);
                  r_beat   <= '0;
                  r_tvalid <= 1'b1;
                  r_tdata  <= r_op[w_base + FL_A];
                  r_tlast  <= FRAME_LEN == 1;
                  r_state  <= S_SEND;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign m00_axis_tvalid = r_tvalid;
   assign m00_axis_tdata  = r_tdata;
   assign m00_axis_tstrb  = '1;
   assign m00_axis_tlast  = r_tlast;
   assign acc_start       = r_acc_start;
   assign s00_axis_tready = r_s_tready;
   assign busy            = r_busy;
   assign done            = r_done;
   assign pass_count      = r_pass;
   assign fail_count      = r_fail;
   assign first_fail_idx  = r_ff_idx;
   assign first_fail_data = r_ff_data;
   assign timeout         = r_timeout;
endmodule
